seq_shift_add_mac: RTL



---
 rtl/rsa_arith_pkg.sv | 15 +
 rtl/seq_shift_add_mac_if.sv | 32 +++
 rtl/seq_shift_add_mac.sv | 90 +++++++++
 3 files changed

// File: rtl/rsa_arith_pkg.sv
// rsa_arith_pkg -- arithmetic types and constants shared by the RSA datapath
// blocks: the nonrestoring divider and the shift-add multiply-accumulator.
//   RSA_WIDTH    : default operand width of the datapath
//   mac_state_t  : control states of seq_shift_add_mac
package rsa_arith_pkg;

  localparam int RSA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

endpackage

// File: rtl/seq_shift_add_mac_if.sv
// seq_shift_add_mac_if -- request/result bundle of the shift-add MAC.
//   start          : request, honoured only while the engine is idle or done
//   A_in/B_in/C_in : multiplicand, multiplier, addend (WIDTH bits each)
//   busy           : engine is stepping
//   done           : one-cycle pulse, P_out/fits_w valid
//   P_out          : A*B+C (2*WIDTH bits), held until the next result
//   fits_w         : upper half of P_out is zero
// master = requester, slave = engine.
interface seq_shift_add_mac_if
  import rsa_arith_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     A_in;
  logic [WIDTH-1:0]     B_in;
  logic [WIDTH-1:0]     C_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   P_out;
  logic                 fits_w;

  modport master (
    output start, A_in, B_in, C_in,
    input  busy, done, P_out, fits_w
  );

  modport slave (
    input  start, A_in, B_in, C_in,
    output busy, done, P_out, fits_w
  );
endinterface

// File: rtl/seq_shift_add_mac.sv
// seq_shift_add_mac -- sequential shift-add multiply-accumulator, P = A*B + C.
// Rebuilds a dividend from the divider's quotient/divisor/remainder and serves
// as the modular-product primitive of the RSA decrypt path.
// Fixed latency: WIDTH RUN steps, then one DONE cycle; a start seen in DONE
// re-enters RUN directly, so throughput is one result per WIDTH+1 cycles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/result bundle (slave side)
module seq_shift_add_mac
  import rsa_arith_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_shift_add_mac_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

  mac_state_t           state, state_nxt;
  logic                 load;
  logic [2*WIDTH-1:0]   acc, mcand, acc_step;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   p_out;
  logic                 fits_w;

  // One step's accumulation; also what P_out captures on the final step, so
  // the result already includes the last partial product when done rises.
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (count == LAST_STEP) state_nxt = DONE;
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      p_out  <= '0;
      fits_w <= 1'b1;
    end else if (load) begin
      acc    <= {{WIDTH{1'b0}}, bus.C_in};
      mcand  <= {{WIDTH{1'b0}}, bus.A_in};
      mplier <= bus.B_in;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == LAST_STEP) begin
        p_out  <= acc_step;
        fits_w <= (acc_step[2*WIDTH-1:WIDTH] == '0);
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.P_out  = p_out;
  assign bus.fits_w = fits_w;

endmodule
